// File: rtl/dht11_emulator.sv
// DHT11 sensor-side responder: answers a host start pulse with the 80/80 us response and a 40-bit frame.
// Optional build macro DHT_EMU_CHECKSUM_ERR_EN enables checksum bit-0 corruption via corrupt_checksum.
module dht11_emulator #(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30,
  parameter int BIT1_HIGH_US  = 70,
  parameter int BIT0_HIGH_US  = 26
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        dht_data,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       corrupt_checksum,
  output logic       drive_low,
  output logic       busy,
  output logic       frame_done,
  output logic       short_start
);

  localparam int CLKS_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int RESP_US     = 80;
  localparam int BIT_LOW_US  = 50;
  localparam int END_LOW_US  = 50;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int US_MAX = max_int(max_int(START_MIN_US, RESP_DELAY_US),
                                  max_int(max_int(RESP_US, BIT_LOW_US),
                                          max_int(BIT1_HIGH_US, BIT0_HIGH_US)));
  localparam int US_W  = $clog2(US_MAX + 1);
  localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST        = PRE_W'(CLKS_PER_US - 1);
  localparam logic [US_W-1:0]  START_MIN       = US_W'(START_MIN_US);
  localparam logic [US_W-1:0]  RESP_DELAY_LAST = US_W'(RESP_DELAY_US - 1);
  localparam logic [US_W-1:0]  RESP_LAST       = US_W'(RESP_US - 1);
  localparam logic [US_W-1:0]  BIT_LOW_LAST    = US_W'(BIT_LOW_US - 1);
  localparam logic [US_W-1:0]  END_LOW_LAST    = US_W'(END_LOW_US - 1);
  localparam logic [US_W-1:0]  BIT1_LAST       = US_W'(BIT1_HIGH_US - 1);
  localparam logic [US_W-1:0]  BIT0_LAST       = US_W'(BIT0_HIGH_US - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST_LOW,
    S_WAIT_REL,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_END_LOW
  } state_t;

  state_t            state, state_next;
  logic [1:0]        sync_q;
  logic              line_q;
  logic [PRE_W-1:0]  pre_cnt;
  logic [US_W-1:0]   us_cnt;
  logic [39:0]       shreg;
  logic [5:0]        bit_cnt;
  logic              tick, listen, fall, rise, state_enter;
  logic              load, shift, short_next, drive_next, busy_next, done_next;
  logic [7:0]        checksum, checksum_tx;

  assign dht_data = drive_low ? 1'b0 : 1'bz;

  assign checksum = hum_int + hum_dec + temp_int + temp_dec;

`ifdef DHT_EMU_CHECKSUM_ERR_EN
  assign checksum_tx = checksum ^ {7'b0, corrupt_checksum};
`else
  logic unused_corrupt_checksum;
  assign unused_corrupt_checksum = corrupt_checksum;
  assign checksum_tx             = checksum;
`endif

  // The synchronizer idles high so leaving reset with a released line is not seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      line_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], dht_data};
      line_q <= sync_q[1];
    end
  end

  assign listen = !drive_low && (state == S_IDLE || state == S_HOST_LOW);
  assign fall   = listen && !sync_q[1] &&  line_q;
  assign rise   = listen &&  sync_q[1] && !line_q;

  assign tick        = (pre_cnt == PRE_LAST);
  assign state_enter = (state_next != state);

  // Prescaler restarts on every state entry so each phase is an exact multiple of CLKS_PER_US.
  always_ff @(posedge clk) begin
    if (reset || state_enter) begin
      pre_cnt <= '0;
      us_cnt  <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      if (us_cnt != '1) us_cnt <= us_cnt + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    short_next = 1'b0;
    case (state)
      S_IDLE:      if (fall) state_next = S_HOST_LOW;
      S_HOST_LOW: begin
        if (rise) begin
          if (us_cnt >= START_MIN) begin
            load       = 1'b1;
            state_next = S_WAIT_REL;
          end else begin
            short_next = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_WAIT_REL:  if (tick && us_cnt == RESP_DELAY_LAST) state_next = S_RESP_LOW;
      S_RESP_LOW:  if (tick && us_cnt == RESP_LAST)       state_next = S_RESP_HIGH;
      S_RESP_HIGH: if (tick && us_cnt == RESP_LAST)       state_next = S_BIT_LOW;
      S_BIT_LOW:   if (tick && us_cnt == BIT_LOW_LAST)    state_next = S_BIT_HIGH;
      S_BIT_HIGH: begin
        if (tick && us_cnt == (shreg[39] ? BIT1_LAST : BIT0_LAST)) begin
          shift      = 1'b1;
          state_next = (bit_cnt == 6'd39) ? S_END_LOW : S_BIT_LOW;
        end
      end
      S_END_LOW:   if (tick && us_cnt == END_LOW_LAST)    state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase

    drive_next = (state_next == S_RESP_LOW) || (state_next == S_BIT_LOW) ||
                 (state_next == S_END_LOW);
    busy_next  = (state_next != S_IDLE) && (state_next != S_HOST_LOW);
    done_next  = (state == S_END_LOW) && (state_next == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      drive_low   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      short_start <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
    end else begin
      state       <= state_next;
      drive_low   <= drive_next;
      busy        <= busy_next;
      frame_done  <= done_next;
      short_start <= short_next;
      if (load) begin
        shreg   <= {hum_int, hum_dec, temp_int, temp_dec, checksum_tx};
        bit_cnt <= '0;
      end else if (shift) begin
        shreg   <= {shreg[38:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dht11_emulator.sv
// Scoreboard bench for dht11_emulator: stimulus queues expected frames, a monitor decodes the line timing.
module tb_dht11_emulator;

  localparam int CLKS      = 2;
  localparam int START_MIN = 100;

  typedef struct {
    logic [39:0] bits;
    bit          aborted;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       host_low = 1'b0;
  logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
  logic       corrupt_checksum = 1'b0;
  logic       drive_low, busy, frame_done, short_start;
  wire        dht_data;

  pullup (dht_data);
  assign dht_data = host_low ? 1'b0 : 1'bz;

  dht11_emulator #(
    .CLK_FREQ_HZ  (CLKS * 1_000_000),
    .START_MIN_US (START_MIN),
    .RESP_DELAY_US(30),
    .BIT1_HIGH_US (70),
    .BIT0_HIGH_US (26)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .dht_data        (dht_data),
    .hum_int         (hum_int),
    .hum_dec         (hum_dec),
    .temp_int        (temp_int),
    .temp_dec        (temp_dec),
    .corrupt_checksum(corrupt_checksum),
    .drive_low       (drive_low),
    .busy            (busy),
    .frame_done      (frame_done),
    .short_start     (short_start)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   frame_id = 0;
  int   done_cnt = 0;
  int   short_cnt = 0;
  int   drv_rise_cnt = 0;
  bit   drv_prev = 1'b0;
  exp_t exp_q[$];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, want);
    end
  endtask

  function automatic logic [39:0] make_frame(input logic [7:0] h, input logic [7:0] hd,
                                             input logic [7:0] t, input logic [7:0] td,
                                             input bit corr);
    logic [7:0] cs;
    cs = h + hd + t + td;
`ifdef DHT_EMU_CHECKSUM_ERR_EN
    cs[0] = cs[0] ^ corr;
`else
    if (corr) cs = cs;
`endif
    return {h, hd, t, td, cs};
  endfunction

  task automatic push_frame(input logic [39:0] bits, input bit aborted);
    exp_t e;
    e.bits    = bits;
    e.aborted = aborted;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (short_start) short_cnt++;
    if (drive_low && !drv_prev) drv_rise_cnt++;
    drv_prev = drive_low;
  end

  // Counts samples (current one included) until drive_low reaches lvl; stops on reset or budget.
  task automatic measure(input logic lvl, output int n, inout bit ab, inout bit to, inout bit bok);
    n = 0;
    while (!ab && !to && drive_low !== lvl) begin
      if (reset) ab = 1'b1;
      else begin
        if (!busy) bok = 1'b0;
        n++;
        if (n > 400 * CLKS) to = 1'b1;
        else @(negedge clk);
      end
    end
  endtask

  task automatic run_frame();
    exp_t        e;
    int          n, want, bi, bad_seg, bad_n, bad_want, terr;
    bit          ab, to, bok;
    logic [39:0] got;
    ab = 0; to = 0; bok = 1; got = '0; terr = 0; bad_seg = -1; bad_n = 0; bad_want = 0;
    frame_id++;
    check(exp_q.size() != 0, "unexpected_frame", 64'(frame_id), 0);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else begin
      e.bits = '0;
      e.aborted = 0;
    end
    for (int seg = 0; seg < 84 && !ab && !to; seg++) begin
      measure((seg % 2 == 0) ? 1'b1 : 1'b0, n, ab, to, bok);
      if (seg == 0) want = 30;
      else if (seg <= 2) want = 80;
      else if (seg == 83 || seg % 2 == 1) want = 50;
      else begin
        bi = (seg - 4) / 2;
        want = e.bits[39 - bi] ? 70 : 26;
        got[39 - bi] = (n > 48 * CLKS);
      end
      if (!ab && !to && n != want * CLKS) begin
        terr++;
        if (bad_seg < 0) begin
          bad_seg = seg; bad_n = n; bad_want = want * CLKS;
        end
      end
    end
    if (to) begin
      check(1'b0, $sformatf("frame%0d_timeout", frame_id), 0, 1);
    end else if (ab) begin
      check(e.aborted, $sformatf("frame%0d_abort_expected", frame_id), 1, 64'(e.aborted));
      @(negedge clk);
      check(!drive_low && !busy, "reset_release", {drive_low, busy}, 0);
    end else begin
      check(!e.aborted, $sformatf("frame%0d_completed", frame_id), 1, 0);
      check(got == e.bits, $sformatf("frame%0d_bits", frame_id), got, e.bits);
      check(terr == 0, $sformatf("frame%0d_timing_seg%0d", frame_id, bad_seg), 64'(bad_n), 64'(bad_want));
      check(bok, $sformatf("frame%0d_busy_held", frame_id), 64'(bok), 1);
      check(frame_done && !busy, $sformatf("frame%0d_end", frame_id), {frame_done, busy}, 2'b10);
      @(negedge clk);
      check(!frame_done, $sformatf("frame%0d_done_width", frame_id), 64'(frame_done), 0);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (busy && !reset) run_frame();
    end
  end

  task automatic host_start(input int us);
    @(posedge clk);
    #1 host_low = 1'b1;
    repeat (us * CLKS) @(posedge clk);
    #1 host_low = 1'b0;
  endtask

  task automatic wait_frame_end(input string name);
    int n;
    n = 0;
    while (!busy && n < 2000) begin @(negedge clk); n++; end
    check(busy, {name, "_start"}, 64'(busy), 1);
    n = 0;
    while (busy && n < 20000) begin @(negedge clk); n++; end
    check(!busy, {name, "_end"}, 64'(busy), 0);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_drv_rises(input int target);
    int n;
    n = 0;
    while (drv_rise_cnt < target && n < 20000) begin @(negedge clk); n++; end
    check(drv_rise_cnt >= target, "drive_rise_wait", 64'(drv_rise_cnt), 64'(target));
  endtask

  task automatic set_data(input logic [7:0] h, input logic [7:0] hd, input logic [7:0] t, input logic [7:0] td);
    hum_int = h; hum_dec = hd; temp_int = t; temp_dec = td;
  endtask

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base_rise, base_frames;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check(!drive_low, "reset_drive_low", 64'(drive_low), 0);
    check(!busy, "reset_busy", 64'(busy), 0);
    check(!frame_done, "reset_frame_done", 64'(frame_done), 0);
    check(!short_start, "reset_short_start", 64'(short_start), 0);

    // Basic frame: 37 00 19 00, checksum 50.
    set_data(8'h37, 8'h00, 8'h19, 8'h00);
    push_frame(40'h3700190050, 0);
    host_start(START_MIN + 20);
    wait_frame_end("t1");

    // Short host low: only short_start reacts.
    base_rise   = drv_rise_cnt;
    base_frames = frame_id;
    host_start(40);
    repeat (200) @(negedge clk);
    check(short_cnt == 1, "t2_short_pulse", 64'(short_cnt), 1);
    check(drv_rise_cnt == base_rise, "t2_no_drive", 64'(drv_rise_cnt), 64'(base_rise));
    check(frame_id == base_frames && !busy, "t2_no_busy", 64'(frame_id), 64'(base_frames));

    // Checksum carry dropped: FF+FF+FF+03 = 0x300 -> 00.
    set_data(8'hFF, 8'hFF, 8'hFF, 8'h03);
    push_frame(40'hFFFFFF0300, 0);
    host_start(START_MIN + 20);
    wait_frame_end("t3");

    // Data change mid-frame does not affect the frame in flight.
    set_data(8'h37, 8'h00, 8'h19, 8'h00);
    push_frame(40'h3700190050, 0);
    base_rise = drv_rise_cnt;
    host_start(START_MIN + 20);
    wait_drv_rises(base_rise + 12);
    temp_int = 8'h20;
    wait_frame_end("t4a");
    push_frame(40'h3700200057, 0);
    host_start(START_MIN + 20);
    wait_frame_end("t4b");

    // Reset during the response low, then a clean frame.
    set_data(8'h37, 8'h00, 8'h19, 8'h00);
    push_frame(40'h3700190050, 1);
    base_rise = drv_rise_cnt;
    host_start(START_MIN + 20);
    wait_drv_rises(base_rise + 1);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (50) @(negedge clk);
    check(!busy && !drive_low, "t5_idle_after_reset", {busy, drive_low}, 0);
    push_frame(40'h3700190050, 0);
    host_start(START_MIN + 20);
    wait_frame_end("t5");

    // Checksum corruption request: honoured only when the macro is built in.
    corrupt_checksum = 1'b1;
    push_frame(make_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b1), 0);
    host_start(START_MIN + 20);
    wait_frame_end("t6");
    corrupt_checksum = 1'b0;

    repeat (20) @(negedge clk);
    check(exp_q.size() == 0, "queue_drained", 64'(exp_q.size()), 0);
    check(done_cnt == 6, "frame_done_count", 64'(done_cnt), 6);
    check(short_cnt == 1, "short_start_count", 64'(short_cnt), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
